// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, constants, queue entry type and pointer sizing for the fetch queue
package ifetch_pkg;
  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ifq_ring.sv
// ifq_ring: {pc,inst} ring storage; pc written at allocation, inst written when memory returns it
module ifq_ring
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              pc_we,
  input  logic [AW-1:0]     pc_addr,
  input  logic [PC_W-1:0]   pc_data,
  input  logic              inst_we,
  input  logic [AW-1:0]     inst_addr,
  input  logic [INST_W-1:0] inst_data,
  input  logic [AW-1:0]     rd_addr,
  output ifq_entry_t        rd_entry
);
  ifq_entry_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (pc_we) mem[pc_addr].pc <= pc_data;
    if (inst_we) mem[inst_addr].inst <= inst_data;
  end
  assign rd_entry = mem[rd_addr];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC owner, credit-limited imem requester and in-order fetch queue feeding decode
module instr_fetch_queue
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst
);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] CAP = (PW+1)'(DEPTH);
  logic [PC_W-1:0] pc;
  logic [PW-1:0] head, fill, tail, drop_cnt, alloc_cnt, drop_nxt;
  logic [PW:0] credit;
  logic run, accept, rsp_fill, deq, filled;
  ifq_entry_t head_entry;
  assign alloc_cnt = tail - head;
  assign filled = fill != head;
  assign credit = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  // run holds requests off for the first cycle after reset so valid depends on state only
  assign imem_req_valid = run && credit < CAP;
  assign imem_req_addr = pc;
  assign accept = imem_req_valid & imem_req_ready;
  assign rsp_fill = imem_rsp_valid && drop_cnt == '0;
  assign deq = filled & id_ready;
  assign id_valid = filled;
  assign id_pc = filled ? head_entry.pc : '0;
  assign id_inst = filled ? head_entry.inst : '0;
  // everything allocated but unreturned, plus a request accepted now, becomes stale on redirect
  assign drop_nxt = drop_cnt + (tail - fill) + PW'(accept) - PW'(imem_rsp_valid);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      head <= '0;
      fill <= '0;
      tail <= '0;
      drop_cnt <= '0;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        pc <= redirect_pc & ~PC_W'(3);
        head <= '0;
        fill <= '0;
        tail <= '0;
        drop_cnt <= drop_nxt;
      end else begin
        if (accept) begin
          pc <= pc + PC_STEP;
          tail <= tail + 1'b1;
        end
        if (rsp_fill) fill <= fill + 1'b1;
        if (imem_rsp_valid && !rsp_fill) drop_cnt <= drop_cnt - 1'b1;
        if (deq) head <= head + 1'b1;
      end
    end
  end
  ifq_ring #(.DEPTH(DEPTH)) u_ring (
    .clk       (clk),
    .pc_we     (accept & ~redirect_valid),
    .pc_addr   (tail[AW-1:0]),
    .pc_data   (pc),
    .inst_we   (rsp_fill & ~redirect_valid),
    .inst_addr (fill[AW-1:0]),
    .inst_data (imem_rsp_data),
    .rd_addr   (head[AW-1:0]),
    .rd_entry  (head_entry)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed scenarios against an in-order latency-programmable memory model
module tb_instr_fetch_queue;
  localparam logic [31:0] MASK = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_pc, id_inst;
  logic w_req_valid, w_id_valid;
  logic [31:0] w_addr, w_id_pc, w_id_inst;
  logic w_ready = 1'b1;
  logic zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;
  int errors = 0;
  int checks = 0;
  int lat = 1;
  int ncyc = 0;
  logic [31:0] q_data[$];
  int q_due[$];
  logic [31:0] acc_log[$];
  always #5 clk = ~clk;
  instr_fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
  );
  instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_req_addr(w_addr),
    .imem_rsp_valid(zero1), .imem_rsp_data(zero32),
    .redirect_valid(zero1), .redirect_pc(zero32),
    .id_valid(w_id_valid), .id_ready(zero1), .id_pc(w_id_pc), .id_inst(w_id_inst)
  );
  // memory: responses presented at negedge, acceptances sampled 1 time unit later
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q_data.delete();
        q_due.delete();
        imem_rsp_valid = 1'b0;
      end else if (q_due.size() > 0 && q_due[0] <= ncyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = q_data.pop_front();
        void'(q_due.pop_front());
      end else imem_rsp_valid = 1'b0;
      #1;
      if (rst && imem_req_valid && imem_req_ready) begin
        q_data.push_back(imem_req_addr ^ MASK);
        q_due.push_back(ncyc + lat);
        acc_log.push_back(imem_req_addr);
        checks++;
        if (q_due.size() > 4) begin
          errors++;
          $display("FAIL credit: outstanding %0d exceeds 4", q_due.size());
        end
      end
      ncyc++;
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    imem_req_ready = 1'b1;
    lat = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    acc_log.delete();
  endtask
  task automatic check_head(input string name, input logic [31:0] pc);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== pc || id_inst !== (pc ^ MASK)) begin
      errors++;
      $display("FAIL %s: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", name, id_valid, id_pc, id_inst, pc, pc ^ MASK);
    end
  endtask
  task automatic check_empty(input string name);
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: id_valid got %b want 0", name, id_valid);
    end
  endtask
  task automatic check_req(input string name, input logic v, input logic [31:0] a);
    checks++;
    if (imem_req_valid !== v || imem_req_addr !== a) begin
      errors++;
      $display("FAIL %s: req got v=%b a=%h want v=%b a=%h", name, imem_req_valid, imem_req_addr, v, a);
    end
  endtask
  task automatic check_reset_outs(input string name);
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      errors++;
      $display("FAIL %s: got rv=%b ra=%h iv=%b pc=%h inst=%h want all 0", name, imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst);
    end
  endtask
  task automatic test_reset();
    #1 rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    imem_req_ready = 1'b1;
    #1 check_reset_outs("reset_outputs");
  endtask
  task automatic test_stream();
    logic [31:0] ep;
    do_reset();
    id_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #2;
      checks++;
      if (id_valid !== (k == 3)) begin
        errors++;
        $display("FAIL first_valid_c%0d: id_valid got %b want %b", k, id_valid, k == 3);
      end
    end
    ep = 0;
    for (int k = 0; k < 8; k++) begin
      check_head("stream", ep);
      ep += 4;
      @(negedge clk);
      #2;
    end
  endtask
  task automatic test_stall();
    logic [31:0] ep;
    do_reset();
    repeat (20) @(negedge clk);
    #2;
    checks++;
    if (acc_log.size() != 4) begin
      errors++;
      $display("FAIL stall_count: requests got %0d want 4", acc_log.size());
    end
    for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
      checks++;
      if (acc_log[i] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stall_addr%0d: got %h want %h", i, acc_log[i], 4 * i);
      end
    end
    check_req("stall_full", 1'b0, 32'h10);
    check_head("stall_head", 32'h0);
    id_ready = 1'b1;
    ep = 0;
    for (int k = 0; k < 6; k++) begin
      check_head("drain", ep);
      ep += 4;
      @(negedge clk);
      #2;
    end
    checks++;
    if (acc_log.size() < 5 || acc_log[4] !== 32'h10) begin
      errors++;
      $display("FAIL resume_addr: got %h want 00000010", acc_log.size() >= 5 ? acc_log[4] : 32'hx);
    end
  endtask
  task automatic test_redirect();
    do_reset();
    lat = 3;
    id_ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check_req("redir_addr", 1'b1, 32'h100);
    check_empty("redir_flush_c4");
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      #2;
      check_empty("redir_drop");
    end
    @(negedge clk);
    #2;
    check_head("redir_first", 32'h100);
    @(negedge clk);
    #2;
    check_head("redir_second", 32'h104);
    checks++;
    if (acc_log.size() < 4 || acc_log[3] !== 32'h100) begin
      errors++;
      $display("FAIL redir_req: 4th request got %h want 00000100", acc_log.size() >= 4 ? acc_log[3] : 32'hx);
    end
  endtask
  task automatic test_redirect_combo();
    do_reset();
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check_req("combo_addr", 1'b1, 32'h200);
    check_empty("combo_flush");
    @(negedge clk);
    #2;
    check_empty("combo_stale_dropped");
    @(negedge clk);
    #2;
    check_head("combo_first", 32'h200);
  endtask
  task automatic test_back_to_back();
    do_reset();
    id_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect_pc = 32'h0000_0083;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check_req("b2b_addr", 1'b1, 32'h80);
    check_empty("b2b_flush");
    @(negedge clk);
    #2;
    check_empty("b2b_stale_dropped");
    @(negedge clk);
    #2;
    check_head("b2b_first", 32'h80);
  endtask
  task automatic test_wrap();
    logic [31:0] wlog[$];
    logic [31:0] exp_w [4];
    exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #2;
      if (w_req_valid) wlog.push_back(w_addr);
    end
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 4", wlog.size());
    end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d: got %h want %h", i, wlog[i], exp_w[i]);
      end
    end
  endtask
  task automatic test_midreset();
    do_reset();
    repeat (8) @(negedge clk);
    #2;
    check_req("mid_full", 1'b0, 32'h10);
    check_head("mid_full_head", 32'h0);
    rst = 1'b0;
    #1 check_reset_outs("mid_reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    acc_log.delete();
    @(negedge clk);
    #2;
    check_req("mid_restart", 1'b1, 32'h0);
    check_empty("mid_restart_empty");
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_combo();
    test_back_to_back();
    test_wrap();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
